// File: rtl/acq_pkg.sv
`default_nettype none
// ============================================================================
// Module : acq_pkg
// Brief  : Shared types and B1 constants for the acquisition search controller
// Rev    : 1.0
// ============================================================================
package acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RUN  = 3'd1,
    ST_WAIT = 3'd2,
    ST_EVAL = 3'd3,
    ST_DONE = 3'd4
  } acq_state_e;

  localparam int C_B1_PRN_LEN       = 2046;
  localparam int C_B1_PRN_PHS_WIDTH = 11;

endpackage
`default_nettype wire

// File: rtl/acq_peak_hold.sv
`default_nettype none
// ============================================================================
// Module : acq_peak_hold
// Brief  : Running maximum of correlator power with the phase that produced it
// Rev    : 1.0
// ============================================================================
module acq_peak_hold #(
  parameter int CORR_ACC_WIDTH = 48,
  parameter int PRN_PHS_WIDTH  = 11
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_clr,
  input  logic                      i_upd,
  input  logic [CORR_ACC_WIDTH-1:0] i_pow,
  input  logic [PRN_PHS_WIDTH-1:0]  i_phs,
  output logic [CORR_ACC_WIDTH-1:0] o_peak,
  output logic [PRN_PHS_WIDTH-1:0]  o_peak_phs,
  output logic [CORR_ACC_WIDTH-1:0] o_peak_nxt
);

  logic [CORR_ACC_WIDTH-1:0] peak_q, peak_d;
  logic [PRN_PHS_WIDTH-1:0]  phs_q, phs_d;
  logic                      take_w;

  // Strict compare so a tie keeps the earlier phase.
  assign take_w     = i_upd && (i_pow > peak_q);
  assign o_peak_nxt = take_w ? i_pow : peak_q;

  always_comb begin
    peak_d = o_peak_nxt;
    phs_d  = take_w ? i_phs : phs_q;
    if (i_clr) begin
      peak_d = '0;
      phs_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      peak_q <= '0;
      phs_q  <= '0;
    end else begin
      peak_q <= peak_d;
      phs_q  <= phs_d;
    end
  end

  assign o_peak     = peak_q;
  assign o_peak_phs = phs_q;

endmodule
`default_nettype wire

// File: rtl/acq_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module : acq_search_ctrl
// Brief  : Serial code-phase search sequencer with peak hold and threshold test
// Rev    : 1.0
// ============================================================================
module acq_search_ctrl
  import acq_pkg::*;
#(
  parameter int PRN_LEN        = C_B1_PRN_LEN,
  parameter int PRN_PHS_WIDTH  = C_B1_PRN_PHS_WIDTH,
  parameter int CORR_ACC_WIDTH = 48,
  parameter int PHS_STEP       = 1,
  parameter int POW_LAT        = 1
) (
  input  logic                      rx_clk,
  input  logic                      rx_rst,
  input  logic                      rx_start,
  input  logic                      rx_smp_vld,
  input  logic [CORR_ACC_WIDTH-1:0] rx_thresh,
  input  logic [CORR_ACC_WIDTH-1:0] rx_corr_pow,
  output logic                      tx_prn_sop,
  output logic                      tx_prn_eop,
  output logic [PRN_PHS_WIDTH-1:0]  tx_loc_phs,
  output logic                      tx_busy,
  output logic                      tx_done,
  output logic                      tx_acq_ok,
  output logic [PRN_PHS_WIDTH-1:0]  tx_acq_phs,
  output logic [CORR_ACC_WIDTH-1:0] tx_acq_peak
);

  localparam logic [PRN_PHS_WIDTH-1:0] C_CHIP_LAST = PRN_PHS_WIDTH'(PRN_LEN - 1);
  localparam logic [2:0]               C_LAT_LAST  = 3'(POW_LAT - 1);
  localparam logic [PRN_PHS_WIDTH:0]   C_PHS_STEP  = (PRN_PHS_WIDTH+1)'(PHS_STEP);
  localparam logic [PRN_PHS_WIDTH:0]   C_PHS_LIMIT = (PRN_PHS_WIDTH+1)'(PRN_LEN);

  acq_state_e                state_q, state_d;
  logic [PRN_PHS_WIDTH-1:0]  chip_q, chip_d;
  logic [PRN_PHS_WIDTH-1:0]  phase_q, phase_d;
  logic [2:0]                lat_q, lat_d;
  logic [CORR_ACC_WIDTH-1:0] pow_q, pow_d;
  logic [CORR_ACC_WIDTH-1:0] thresh_q, thresh_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic                      acq_ok_q, acq_ok_d;

  logic                      clr_w, upd_w, sop_w, eop_w;
  logic [PRN_PHS_WIDTH:0]    phs_sum_w;
  logic [CORR_ACC_WIDTH-1:0] peak_nxt_w;

  assign sop_w     = (state_q == ST_RUN) && rx_smp_vld && (chip_q == '0);
  assign eop_w     = (state_q == ST_RUN) && rx_smp_vld && (chip_q == C_CHIP_LAST);
  assign phs_sum_w = {1'b0, phase_q} + C_PHS_STEP;

  always_comb begin
    state_d  = state_q;
    chip_d   = chip_q;
    phase_d  = phase_q;
    lat_d    = lat_q;
    pow_d    = pow_q;
    thresh_d = thresh_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    acq_ok_d = acq_ok_q;
    clr_w    = 1'b0;
    upd_w    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_start) begin
          state_d  = ST_RUN;
          chip_d   = '0;
          phase_d  = '0;
          busy_d   = 1'b1;
          acq_ok_d = 1'b0;
          thresh_d = rx_thresh;
          clr_w    = 1'b1;
        end
      end
      ST_RUN: begin
        if (eop_w) begin
          chip_d = '0;
          lat_d  = '0;
          if (POW_LAT == 0) begin
            pow_d   = rx_corr_pow;
            state_d = ST_EVAL;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (rx_smp_vld) begin
          chip_d = chip_q + PRN_PHS_WIDTH'(1);
        end
      end
      ST_WAIT: begin
        if (lat_q == C_LAT_LAST) begin
          pow_d   = rx_corr_pow;
          state_d = ST_EVAL;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      ST_EVAL: begin
        upd_w = 1'b1;
        // Threshold uses the peak including this last trial.
        if (phs_sum_w >= C_PHS_LIMIT) begin
          state_d  = ST_DONE;
          done_d   = 1'b1;
          acq_ok_d = (peak_nxt_w > thresh_q);
        end else begin
          phase_d = phs_sum_w[PRN_PHS_WIDTH-1:0];
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      state_q  <= ST_IDLE;
      chip_q   <= '0;
      phase_q  <= '0;
      lat_q    <= '0;
      pow_q    <= '0;
      thresh_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      acq_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      chip_q   <= chip_d;
      phase_q  <= phase_d;
      lat_q    <= lat_d;
      pow_q    <= pow_d;
      thresh_q <= thresh_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      acq_ok_q <= acq_ok_d;
    end
  end

  acq_peak_hold #(
    .CORR_ACC_WIDTH (CORR_ACC_WIDTH),
    .PRN_PHS_WIDTH  (PRN_PHS_WIDTH)
  ) u_peak_hold (
    .clk        (rx_clk),
    .rst        (rx_rst),
    .i_clr      (clr_w),
    .i_upd      (upd_w),
    .i_pow      (pow_q),
    .i_phs      (phase_q),
    .o_peak     (tx_acq_peak),
    .o_peak_phs (tx_acq_phs),
    .o_peak_nxt (peak_nxt_w)
  );

  assign tx_prn_sop = sop_w;
  assign tx_prn_eop = eop_w;
  assign tx_loc_phs = phase_q;
  assign tx_busy    = busy_q;
  assign tx_done    = done_q;
  assign tx_acq_ok  = acq_ok_q;

endmodule
`default_nettype wire

// File: tb/tb_acq_search_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_acq_search_ctrl
// Brief  : Self-checking bench, PRN_LEN=8; second instance uses PHS_STEP=3
// Rev    : 1.0
// ============================================================================
module tb_acq_search_ctrl;

  localparam int W = 48;
  localparam int P = 11;
  localparam logic [W-1:0] C_MAX = {W{1'b1}};

  typedef logic [7:0][W-1:0] pat_t;
  typedef struct packed {
    pat_t         pow;
    logic [W-1:0] thresh;
    logic [P-1:0] phs;
    logic [W-1:0] peak;
    logic         ok;
  } vec_t;
  typedef struct packed {
    logic [P-1:0] phs;
    logic [W-1:0] peak;
    logic         ok;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, vld = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;
  logic [W-1:0] thresh_a = '0, thresh_b = '0;
  pat_t pat_a = '0, pat_b = '0;
  int   vld_mode = 0;

  logic sop_a, eop_a, busy_a, done_a, ok_a;
  logic [P-1:0] loc_a, phs_a;
  logic [W-1:0] peak_a, pow_a;
  logic sop_b, eop_b, busy_b, done_b, ok_b;
  logic [P-1:0] loc_b, phs_b;
  logic [W-1:0] peak_b, pow_b;

  assign pow_a = pat_a[loc_a[2:0]];
  assign pow_b = pat_b[loc_b[2:0]];

  always #5 clk = ~clk;

  acq_search_ctrl #(.PRN_LEN(8), .PRN_PHS_WIDTH(P), .CORR_ACC_WIDTH(W),
                    .PHS_STEP(1), .POW_LAT(1)) u_dut_a (
    .rx_clk(clk), .rx_rst(rst), .rx_start(start_a), .rx_smp_vld(vld),
    .rx_thresh(thresh_a), .rx_corr_pow(pow_a),
    .tx_prn_sop(sop_a), .tx_prn_eop(eop_a), .tx_loc_phs(loc_a), .tx_busy(busy_a),
    .tx_done(done_a), .tx_acq_ok(ok_a), .tx_acq_phs(phs_a), .tx_acq_peak(peak_a));

  acq_search_ctrl #(.PRN_LEN(8), .PRN_PHS_WIDTH(P), .CORR_ACC_WIDTH(W),
                    .PHS_STEP(3), .POW_LAT(1)) u_dut_b (
    .rx_clk(clk), .rx_rst(rst), .rx_start(start_b), .rx_smp_vld(vld),
    .rx_thresh(thresh_b), .rx_corr_pow(pow_b),
    .tx_prn_sop(sop_b), .tx_prn_eop(eop_b), .tx_loc_phs(loc_b), .tx_busy(busy_b),
    .tx_done(done_b), .tx_acq_ok(ok_b), .tx_acq_phs(phs_b), .tx_acq_peak(peak_b));

  int n_tests = 0, n_fail = 0;
  exp_t sb_a[$], sb_b[$];
  logic [P-1:0] ph_b[$];

  // Monitor statistics, sampled on the falling edge.
  int viol = 0, idle_se = 0, done_cnt = 0, eop_cnt = 0, done_cnt_b = 0;
  int periods = 0, bad_per = 0, phs_chg = 0, strobes = 0;
  logic in_per = 1'b0;
  logic [P-1:0] per_phs = '0;

  initial begin : g_vld_drv
    int cyc;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      vld = (vld_mode == 0) ? 1'b1 : ((cyc % 3) == 0);
    end
  end

  always @(negedge clk) begin
    if ((sop_a || eop_a) && !vld) viol++;
    if ((sop_a || eop_a) && !busy_a) idle_se++;
    if (done_a) done_cnt++;
    if (done_b) done_cnt_b++;
    if (eop_a) eop_cnt++;
    if (sop_a) begin
      in_per  = 1'b1;
      strobes = 1;
      per_phs = loc_a;
    end else if (in_per && vld) begin
      strobes++;
      if (loc_a != per_phs) phs_chg++;
    end
    if (eop_a) begin
      in_per = 1'b0;
      periods++;
      if (strobes != 8) bad_per++;
    end
    if (eop_b) ph_b.push_back(loc_b);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic pat_t mk_pat(input logic [W-1:0] base, input int p1,
                                  input logic [W-1:0] v1, input int p2,
                                  input logic [W-1:0] v2);
    pat_t r;
    for (int i = 0; i < 8; i++) r[i] = base;
    if (p1 >= 0) r[p1] = v1;
    if (p2 >= 0) r[p2] = v2;
    return r;
  endfunction

  task automatic start_search_a(input vec_t v);
    exp_t e;
    pat_a    = v.pow;
    thresh_a = v.thresh;
    e.phs = v.phs; e.peak = v.peak; e.ok = v.ok;
    sb_a.push_back(e);
    eop_cnt = 0; periods = 0; bad_per = 0; phs_chg = 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input string tag, input int budget);
    bit   found;
    int   d0;
    exp_t e;
    found = 0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_a) begin found = 1; break; end
    end
    if (!found) begin
      check({tag, " done timeout"}, 64'd0, 64'd1);
      return;
    end
    if (sb_a.size() == 0) begin
      check({tag, " scoreboard empty"}, 64'd0, 64'd1);
      return;
    end
    e = sb_a.pop_front();
    check({tag, " acq_phs"},  64'(phs_a),  64'(e.phs));
    check({tag, " acq_peak"}, 64'(peak_a), 64'(e.peak));
    check({tag, " acq_ok"},   64'(ok_a),   64'(e.ok));
    check({tag, " busy@done"}, 64'(busy_a), 64'd1);
    repeat (3) tick();
    @(negedge clk);
    check({tag, " single done"}, 64'(done_cnt - d0), 64'd1);
    check({tag, " trials"},      64'(eop_cnt),       64'd8);
    check({tag, " busy after"},  64'(busy_a),        64'd0);
    check({tag, " ok held"},     64'(ok_a),          64'(e.ok));
  endtask

  task automatic wait_phase_a(input logic [P-1:0] p, input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy_a && loc_a == p) begin found = 1; break; end
    end
    if (!found) check("phase wait timeout", 64'd0, 64'd1);
  endtask

  vec_t vecs[6];

  initial begin : g_main
    int   d0;
    exp_t eb;
    bit   found;

    vecs[0] = '{pow: mk_pat(3, 5, 55, -1, 0), thresh: 50,        phs: 5, peak: 55,    ok: 1'b1};
    vecs[1] = '{pow: mk_pat(3, 5, 55, -1, 0), thresh: 55,        phs: 5, peak: 55,    ok: 1'b0};
    vecs[2] = '{pow: mk_pat(1, 2, 7, 6, 7),   thresh: 6,         phs: 2, peak: 7,     ok: 1'b1};
    vecs[3] = '{pow: mk_pat(0, -1, 0, -1, 0), thresh: 0,         phs: 0, peak: 0,     ok: 1'b0};
    vecs[4] = '{pow: mk_pat(0, 7, C_MAX, -1, 0), thresh: C_MAX - 1, phs: 7, peak: C_MAX, ok: 1'b1};
    vecs[5] = '{pow: mk_pat(9, -1, 0, -1, 0), thresh: 9,         phs: 0, peak: 9,     ok: 1'b0};

    // Reset and idle.
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst sop",  64'(sop_a),  64'd0);
    check("rst eop",  64'(eop_a),  64'd0);
    check("rst loc",  64'(loc_a),  64'd0);
    check("rst busy", 64'(busy_a), 64'd0);
    check("rst done", 64'(done_a), 64'd0);
    check("rst ok",   64'(ok_a),   64'd0);
    check("rst phs",  64'(phs_a),  64'd0);
    check("rst peak", 64'(peak_a), 64'd0);
    vld_mode = 1;
    repeat (12) tick();
    vld_mode = 0;
    repeat (4) tick();
    check("idle sop/eop", 64'(idle_se), 64'd0);

    // Table of complete searches with continuous samples.
    for (int k = 0; k < 6; k++) begin
      start_search_a(vecs[k]);
      wait_done_a($sformatf("vec%0d", k), 400);
    end

    // Sparse sample strobes.
    vld_mode = 1;
    start_search_a(vecs[0]);
    wait_done_a("duty3", 800);
    check("duty3 periods",      64'(periods), 64'd8);
    check("duty3 bad periods",  64'(bad_per), 64'd0);
    check("duty3 phase change", 64'(phs_chg), 64'd0);
    vld_mode = 0;

    // Start pulse during a search must not restart nor relatch threshold.
    start_search_a(vecs[0]);
    wait_phase_a(3, 200);
    tick();
    start_a  = 1'b1;
    thresh_a = 100;
    tick();
    start_a  = 1'b0;
    wait_done_a("mid start", 400);

    // Reset mid-search.
    start_search_a(vecs[2]);
    wait_phase_a(4, 200);
    d0 = done_cnt;
    void'(sb_a.pop_front());
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mrst busy", 64'(busy_a), 64'd0);
    check("mrst loc",  64'(loc_a),  64'd0);
    check("mrst peak", 64'(peak_a), 64'd0);
    check("mrst phs",  64'(phs_a),  64'd0);
    check("mrst ok",   64'(ok_a),   64'd0);
    repeat (30) tick();
    check("mrst no done", 64'(done_cnt - d0), 64'd0);
    start_search_a(vecs[2]);
    wait_done_a("after rst", 400);

    // Coarse step instance: phases 0,3,6.
    for (int i = 0; i < 8; i++) pat_b[i] = W'(2 * i + 1);
    pat_b[3] = 20;
    thresh_b = 19;
    eb.phs = 3; eb.peak = 20; eb.ok = 1'b1;
    sb_b.push_back(eb);
    ph_b.delete();
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    found = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done_b) begin found = 1; break; end
    end
    if (!found) begin
      check("step3 done timeout", 64'd0, 64'd1);
    end else begin
      eb = sb_b.pop_front();
      check("step3 acq_phs",  64'(phs_b),  64'(eb.phs));
      check("step3 acq_peak", 64'(peak_b), 64'(eb.peak));
      check("step3 acq_ok",   64'(ok_b),   64'(eb.ok));
      repeat (3) tick();
      check("step3 trials",      64'(ph_b.size()), 64'd3);
      check("step3 single done", 64'(done_cnt_b),  64'd1);
      if (ph_b.size() == 3) begin
        check("step3 phase0", 64'(ph_b[0]), 64'd0);
        check("step3 phase1", 64'(ph_b[1]), 64'd3);
        check("step3 phase2", 64'(ph_b[2]), 64'd6);
      end
    end

    check("sop/eop without strobe", 64'(viol),    64'd0);
    check("sop/eop while idle",     64'(idle_se), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : g_watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
